// File: rtl/acl_spi_pkg.sv
// rtl/acl_spi_pkg.sv - shared types and constants for the accelerometer SPI slot core
package acl_spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPHA_DLY = 2'd1,
        P0       = 2'd2,
        P1       = 2'd3
    } spi_state_e;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_SS     = 2'd1;
    localparam logic [1:0] REG_WR     = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int CTRL_DVSR_LSB = 0;
    localparam int CTRL_DVSR_MSB = 15;
    localparam int CTRL_CPOL_BIT = 16;
    localparam int CTRL_CPHA_BIT = 17;

    // SCLK level held while in a given state; IDLE and CPHA_DLY sit at the idle polarity.
    function automatic logic sclk_level(spi_state_e st, logic cpol, logic cpha);
        logic p_clk;
        p_clk = ((st == P1) && !cpha) || ((st == P0) && cpha);
        return p_clk ^ cpol;
    endfunction

endpackage

// File: rtl/spi_engine.sv
// rtl/spi_engine.sv - byte-wide full-duplex SPI master FSM, divider and shifters
module spi_engine
    import acl_spi_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic [7:0]  din_i,
    input  logic [15:0] dvsr_i,
    input  logic        cpol_i,
    input  logic        cpha_i,
    input  logic        miso_i,
    output logic [7:0]  dout_o,
    output logic        ready_o,
    output logic        sclk_o,
    output logic        mosi_o
);

    spi_state_e  state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  tx_q;
    logic [7:0]  rx_q;
    logic [7:0]  dout_q;
    logic        ready_q;
    logic        sclk_q;
    logic [15:0] dvsr_w_q;
    logic        cpol_w_q;
    logic        cpha_w_q;
    logic        last;

    assign last = (cnt_q == dvsr_w_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            dout_q   <= '0;
            ready_q  <= 1'b1;
            sclk_q   <= 1'b0;
            dvsr_w_q <= '0;
            cpol_w_q <= 1'b0;
            cpha_w_q <= 1'b0;
        end else if (state_q == IDLE) begin
            sclk_q <= cpol_i;
            if (start_i) begin
                // Working copies keep a mid-transfer ctrl write from disturbing this byte.
                dvsr_w_q <= dvsr_i;
                cpol_w_q <= cpol_i;
                cpha_w_q <= cpha_i;
                tx_q     <= din_i;
                bit_q    <= '0;
                cnt_q    <= '0;
                ready_q  <= 1'b0;
                state_q  <= cpha_i ? CPHA_DLY : P0;
            end
        end else if (!last) begin
            cnt_q <= cnt_q + 16'd1;
        end else begin
            cnt_q <= '0;
            if (state_q == CPHA_DLY) begin
                state_q <= P0;
                sclk_q  <= sclk_level(P0, cpol_w_q, cpha_w_q);
            end else if (state_q == P0) begin
                rx_q    <= {rx_q[6:0], miso_i};
                state_q <= P1;
                sclk_q  <= sclk_level(P1, cpol_w_q, cpha_w_q);
            end else begin
                tx_q <= {tx_q[6:0], 1'b0};
                if (bit_q == 3'd7) begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    dout_q  <= rx_q;
                    sclk_q  <= cpol_w_q;
                end else begin
                    bit_q   <= bit_q + 3'd1;
                    state_q <= P0;
                    sclk_q  <= sclk_level(P0, cpol_w_q, cpha_w_q);
                end
            end
        end
    end

    assign dout_o  = dout_q;
    assign ready_o = ready_q;
    assign sclk_o  = sclk_q;
    assign mosi_o  = tx_q[7];

endmodule

// File: rtl/acl_spi_core.sv
// rtl/acl_spi_core.sv - MMIO slot wrapper: register decode, slave selects, ctrl and status
module acl_spi_core
    import acl_spi_pkg::*;
#(
    parameter int          N_SS     = 1,
    parameter logic [15:0] DVSR_RST = 16'd49
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cs,
    input  logic            read,
    input  logic            write,
    input  logic [4:0]      addr,
    input  logic [31:0]     wr_data,
    output logic [31:0]     rd_data,
    output logic            spi_sclk,
    output logic            spi_mosi,
    input  logic            spi_miso,
    output logic [N_SS-1:0] spi_ss_n
);

    logic [N_SS-1:0] ss_n_q;
    logic [15:0]     dvsr_q;
    logic            cpol_q;
    logic            cpha_q;
    logic            wr_en;
    logic            start;
    logic            ready;
    logic [7:0]      rx_byte;
    logic            unused_ok;

    assign wr_en = cs & write;
    assign start = wr_en && (addr[1:0] == REG_WR);

    // Reads have no side effects and only addr[1:0] is decoded.
    assign unused_ok = &{1'b0, read, addr[4:2], wr_data[31:18]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ss_n_q <= '1;
            dvsr_q <= DVSR_RST;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
        end else if (wr_en) begin
            if (addr[1:0] == REG_SS) begin
                ss_n_q <= wr_data[N_SS-1:0];
            end
            if (addr[1:0] == REG_CTRL) begin
                dvsr_q <= wr_data[CTRL_DVSR_MSB:CTRL_DVSR_LSB];
                cpol_q <= wr_data[CTRL_CPOL_BIT];
                cpha_q <= wr_data[CTRL_CPHA_BIT];
            end
        end
    end

    spi_engine u_engine (
        .clk     (clk),
        .reset_n (reset_n),
        .start_i (start),
        .din_i   (wr_data[7:0]),
        .dvsr_i  (dvsr_q),
        .cpol_i  (cpol_q),
        .cpha_i  (cpha_q),
        .miso_i  (spi_miso),
        .dout_o  (rx_byte),
        .ready_o (ready),
        .sclk_o  (spi_sclk),
        .mosi_o  (spi_mosi)
    );

    assign rd_data  = {23'b0, ready, rx_byte};
    assign spi_ss_n = ss_n_q;

endmodule

// File: tb/tb_acl_spi_core.sv
// tb/tb_acl_spi_core.sv - randomized scoreboard bench for acl_spi_core with an SPI slave model
module tb_acl_spi_core;

    localparam logic [1:0] A_SS   = 2'd1;
    localparam logic [1:0] A_WR   = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;
    localparam int         LIMIT  = 20000;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         len;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs, read, write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        spi_sclk, spi_mosi, spi_miso;
    logic [0:0]  spi_ss_n;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    int         cur_dvsr;
    logic       cur_cpol, cur_cpha;
    logic       s_loop, s_cpha;
    logic [7:0] s_resp;
    int         xfer_seq = 0;
    int         seen_seq = 0;
    int         e = 0;
    logic [7:0] cap = 8'h00;
    int         miso_k;

    always #5 clk = ~clk;

    acl_spi_core #(.N_SS(1), .DVSR_RST(16'd49)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cs       (cs),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_ss_n (spi_ss_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Slave device: counts SCLK edges per transfer, captures MOSI on its sampling edge.
    always @(spi_sclk or xfer_seq) begin
        if (xfer_seq != seen_seq) begin
            seen_seq = xfer_seq;
            e        = 0;
            cap      = 8'h00;
        end else if (reset_n === 1'b1) begin
            e++;
            if ((s_cpha && (e % 2 == 0)) || (!s_cpha && (e % 2 == 1)))
                cap = {cap[6:0], spi_mosi};
        end
    end

    always_comb begin
        miso_k = s_cpha ? ((e == 0) ? 0 : (e - 1) / 2) : e / 2;
        if (s_loop)
            spi_miso = spi_mosi;
        else if (miso_k > 7)
            spi_miso = 1'b0;
        else
            spi_miso = s_resp[3'(7 - miso_k)];
    end

    // Monitor: each rising edge of ready is one completed byte.
    int   busy_cnt = 0;
    logic prev_ready = 1'b1;
    always @(negedge clk) begin
        exp_t x;
        if (reset_n !== 1'b1) begin
            busy_cnt   = 0;
            prev_ready = 1'b1;
        end else begin
            if (rd_data[8] == 1'b0) busy_cnt++;
            if (rd_data[8] && !prev_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    x = sb.pop_front();
                    chk("rd_data", rd_data, {23'b0, 1'b1, x.rx});
                    chk("busy_clocks", busy_cnt, x.len);
                    chk("mosi_byte", {24'b0, cap}, {24'b0, x.tx});
                    chk("sclk_edges", e, 32'd16);
                end
                busy_cnt = 0;
            end
            prev_ready = rd_data[8];
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        cs      = 1'b1;
        write   = 1'b1;
        read    = 1'($urandom_range(0, 1));
        addr    = {3'($urandom_range(0, 7)), a};
        wr_data = d;
        @(posedge clk);
        #1;
        cs    = 1'b0;
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic write_ctrl(input logic [31:0] d);
        bus_write(A_CTRL, d);
        cur_dvsr = int'(d[15:0]);
        cur_cpol = d[16];
        cur_cpha = d[17];
    endtask

    task automatic do_start(input logic [7:0] tx, input logic loop, input logic [7:0] resp,
                            input logic push);
        exp_t x;
        @(posedge clk);
        #1;
        s_loop = loop;
        s_resp = resp;
        s_cpha = cur_cpha;
        xfer_seq++;
        if (push) begin
            x.tx  = tx;
            x.rx  = loop ? tx : resp;
            x.len = (16 + (cur_cpha ? 1 : 0)) * (cur_dvsr + 1);
            sb.push_back(x);
        end
        cs      = 1'b1;
        write   = 1'b1;
        addr    = {3'($urandom_range(0, 7)), A_WR};
        wr_data = {24'($urandom), tx};
        @(posedge clk);
        #1;
        cs    = 1'b0;
        write = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || rd_data[8] !== 1'b1) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("xfer_timeout", 32'(n >= LIMIT), 32'd0);
    endtask

    initial begin
        logic [31:0] c;
        cs = 0; write = 0; read = 0; addr = 0; wr_data = 0;
        reset_n = 1'b0;
        s_loop = 1'b1; s_cpha = 1'b0; s_resp = 8'h00;
        cur_dvsr = 49; cur_cpol = 1'b0; cur_cpha = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        chk("reset_rd_data", rd_data, 32'h0000_0100);
        chk("reset_sclk", {31'b0, spi_sclk}, 32'd0);
        chk("reset_ss_n", {31'b0, spi_ss_n}, 32'd1);
        chk("reset_mosi", {31'b0, spi_mosi}, 32'd0);

        // Mode 0 loopback
        write_ctrl(32'h0000_0001);
        bus_write(A_SS, 32'h0);
        chk("ss_n_write", {31'b0, spi_ss_n}, 32'd0);
        do_start(8'hA5, 1'b1, 8'h00, 1'b1);
        wait_done();

        // Mode 3, slave answers all ones
        write_ctrl(32'h0003_0003);
        repeat (2) @(posedge clk);
        #1 chk("sclk_idle_cpol1", {31'b0, spi_sclk}, 32'd1);
        do_start(8'h3C, 1'b0, 8'hFF, 1'b1);
        wait_done();

        // Start while busy is dropped
        write_ctrl(32'h0000_0001);
        do_start(8'h12, 1'b1, 8'h00, 1'b1);
        repeat (3) @(posedge clk);
        bus_write(A_WR, 32'h34);
        wait_done();

        // Ctrl write mid-transfer only affects the next byte
        do_start(8'h69, 1'b1, 8'h00, 1'b1);
        repeat (3) @(posedge clk);
        write_ctrl(32'h0000_0009);
        wait_done();
        do_start(8'hC3, 1'b0, 8'h5E, 1'b1);
        wait_done();

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                c = {14'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     16'($urandom_range(0, 4))};
                write_ctrl(c);
            end
            do_start(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                c = {14'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     16'($urandom_range(0, 4))};
                write_ctrl(c);
            end
            if ($urandom_range(0, 2) == 0)
                bus_write(A_WR, $urandom);
            wait_done();
        end

        // Reset in the middle of a transfer
        write_ctrl(32'h0000_0001);
        do_start(8'h5A, 1'b1, 8'h00, 1'b0);
        repeat (9) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("abort_sclk", {31'b0, spi_sclk}, 32'd0);
        chk("abort_ss_n", {31'b0, spi_ss_n}, 32'd1);
        chk("abort_rd_data", rd_data, 32'h0000_0100);
        chk("abort_mosi", {31'b0, spi_mosi}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("post_abort_rd_data", rd_data, 32'h0000_0100);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
